loader_write_buffer: RTL and testbench

- Sits directly downstream of the ROM/BIOS/NSF game loader, between its byte-write strobe (mem_addr/mem_data/mem_write) and the SDRAM controller's download write port.
- The loader emits single-cycle writes with no back-pressure. This block queues them in a small FIFO and replays each one to SDRAM using a req/ack handshake.
- It reports occupancy, overflow and ack-timeout, so the loader's busy/done can be qualified until every byte has actually landed in SDRAM.

---
 rtl/loader_pkg.sv | 16 +
 rtl/loader_wb_fifo.sv | 62 ++++++
 rtl/loader_write_buffer.sv | 141 ++++++++++++++
 tb/tb_loader_write_buffer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types for the loader write buffer: FSM state and the queued write entry.
package loader_pkg;

  localparam int LOADER_ADDR_W = 22;

  typedef enum logic {
    S_IDLE,
    S_REQ
  } wb_state_t;

  typedef struct packed {
    logic [LOADER_ADDR_W-1:0] addr;
    logic [7:0]               data;
  } wb_entry_t;

endpackage

// File: rtl/loader_wb_fifo.sv
// Synchronous FIFO of loader write entries; the caller guarantees push only when
// there is room (or a pop on the same edge) and pop only when not empty.
module loader_wb_fifo
  import loader_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                push,
  input  logic                pop,
  input  wb_entry_t           push_entry,
  output wb_entry_t           head_entry,
  output logic [DEPTH_LOG2:0] level,
  output logic                full,
  output logic                empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  wb_entry_t             mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;

  // Occupancy is kept as its own count so a full FIFO and an empty one differ
  // even though the wrapped pointers are equal in both cases.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_entry;
  end

  assign head_entry = mem_q[rd_ptr_q];
  assign level      = level_q;
  assign full       = (level_q == (DEPTH_LOG2+1)'(DEPTH));
  assign empty      = (level_q == '0);

endmodule

// File: rtl/loader_write_buffer.sv
// Queues single-cycle loader writes and replays them to SDRAM over a req/ack
// handshake, with sticky overflow and ack-timeout reporting.
module loader_write_buffer
  import loader_pkg::*;
#(
  parameter int ADDR_W     = LOADER_ADDR_W,
  parameter int DEPTH_LOG2 = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                downloading,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [7:0]          wr_data,
  output logic                mem_req,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [7:0]          mem_din,
  input  logic                mem_ack,
  output logic [DEPTH_LOG2:0] level,
  output logic                busy,
  output logic                overflow,
  output logic                timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  wb_state_t         state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_din_q, mem_din_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              overflow_q, overflow_d;
  logic              timeout_err_q, timeout_err_d;
  logic              downloading_q;

  logic      fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic      drop, dl_rise;
  wb_entry_t push_entry, head_entry;

  assign push_entry.addr = wr_addr;
  assign push_entry.data = wr_data;

  loader_wb_fifo #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (fifo_push),
    .pop       (fifo_pop),
    .push_entry(push_entry),
    .head_entry(head_entry),
    .level     (level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Handshake FSM: a pop always reloads the request registers on the same edge,
  // so an ack with more data queued keeps mem_req high without a gap.
  always_comb begin
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    cnt_d      = cnt_q;
    fifo_pop   = 1'b0;
    timeout_err_d = timeout_err_q;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          mem_req_d  = 1'b1;
          mem_addr_d = head_entry.addr;
          mem_din_d  = head_entry.data;
          cnt_d      = '0;
          state_d    = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            mem_addr_d = head_entry.addr;
            mem_din_d  = head_entry.data;
            cnt_d      = '0;
          end else begin
            mem_req_d = 1'b0;
            state_d   = S_IDLE;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          mem_req_d     = 1'b0;
          timeout_err_d = 1'b1;
          cnt_d         = '0;
          state_d       = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A rising edge of downloading clears the sticky flags; a new event on the
    // same edge still wins so it is never lost.
    dl_rise    = downloading && !downloading_q;
    drop       = wr_en && fifo_full && !fifo_pop;
    fifo_push  = wr_en && !drop;
    overflow_d = (overflow_q && !dl_rise) || drop;
    if (dl_rise && !(state_q == S_REQ && !mem_ack && cnt_q == CNT_W'(TIMEOUT - 1)))
      timeout_err_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      mem_din_q     <= '0;
      cnt_q         <= '0;
      overflow_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      downloading_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      mem_din_q     <= mem_din_d;
      cnt_q         <= cnt_d;
      overflow_q    <= overflow_d;
      timeout_err_q <= timeout_err_d;
      downloading_q <= downloading;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign mem_din     = mem_din_q;
  assign overflow    = overflow_q;
  assign timeout_err = timeout_err_q;
  assign busy        = (level != '0) || mem_req_q;

endmodule

// File: tb/tb_loader_write_buffer.sv
// Randomised and directed bench for loader_write_buffer against a queue-based
// model of the buffer's write/replay rules.
module tb_loader_write_buffer;

  localparam int ADDR_W     = 22;
  localparam int DEPTH_LOG2 = 4;
  localparam int DEPTH      = 1 << DEPTH_LOG2;
  localparam int TIMEOUT    = 255;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              downloading = 1'b0;
  logic              wr_en = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [7:0]        wr_data = '0;
  logic              mem_ack = 1'b0;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_din;
  logic [DEPTH_LOG2:0] level;
  logic              busy, overflow, timeout_err;

  int checks = 0;
  int errors = 0;

  loader_write_buffer #(
    .ADDR_W(ADDR_W), .DEPTH_LOG2(DEPTH_LOG2), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .downloading(downloading),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_ack(mem_ack), .level(level), .busy(busy),
    .overflow(overflow), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Behavioural model: pending writes live in a queue; one entry may be in flight.
  logic [ADDR_W+7:0] mq[$];
  logic [ADDR_W+7:0] m_e;
  bit                m_req = 0, m_ovf = 0, m_terr = 0, m_dl = 0, started = 0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [7:0]        m_din = '0;
  int                m_cnt = 0;
  int                m_sz;
  bit                m_popped, m_rise;

  always @(posedge clk) begin
    started = 1;
    if (!reset_n) begin
      mq.delete();
      m_req = 0; m_addr = '0; m_din = '0; m_cnt = 0;
      m_ovf = 0; m_terr = 0; m_dl = 0;
    end else begin
      m_sz = mq.size();
      m_popped = 0;
      m_rise = downloading && !m_dl;
      if (m_rise) begin m_ovf = 0; m_terr = 0; end
      if (!m_req || mem_ack) begin
        if (m_sz > 0) begin
          m_e = mq.pop_front();
          m_addr = m_e[ADDR_W+7:8];
          m_din = m_e[7:0];
          m_req = 1; m_cnt = 0; m_popped = 1;
        end else begin
          m_req = 0;
        end
      end else if (m_cnt == TIMEOUT - 1) begin
        m_req = 0; m_terr = 1; m_cnt = 0;
      end else begin
        m_cnt++;
      end
      if (wr_en) begin
        if (m_sz < DEPTH || m_popped) mq.push_back({wr_addr, wr_data});
        else m_ovf = 1;
      end
      m_dl = downloading;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      checkOutput("mem_req",     32'(mem_req),     32'(m_req));
      checkOutput("mem_addr",    32'(mem_addr),    32'(m_addr));
      checkOutput("mem_din",     32'(mem_din),     32'(m_din));
      checkOutput("level",       32'(level),       32'(mq.size()));
      checkOutput("busy",        32'(busy),        32'(mq.size() != 0 || m_req));
      checkOutput("overflow",    32'(overflow),    32'(m_ovf));
      checkOutput("timeout_err", 32'(timeout_err), 32'(m_terr));
    end
  end

  // Inputs change 2 time units after the rising edge and are taken on the next one.
  task automatic applyStimulus(input bit we, input logic [ADDR_W-1:0] a,
                               input logic [7:0] d, input bit ack);
    wr_en = we; wr_addr = a; wr_data = d; mem_ack = ack;
    @(posedge clk);
    #2;
    wr_en = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    applyStimulus(0, '0, '0, 0);
    applyStimulus(0, '0, '0, 0);
    reset_n = 1'b1;
  endtask

  int n;

  initial begin
    $display("[TB] start");
    doReset();
    checkOutput("reset_level", 32'(level), 32'd0);
    checkOutput("reset_req",   32'(mem_req), 32'd0);
    checkOutput("reset_busy",  32'(busy), 32'd0);

    // Single write: request appears two edges after the strobe.
    applyStimulus(1, 22'h000010, 8'hA5, 0);
    checkOutput("sw_level1", 32'(level), 32'd1);
    checkOutput("sw_req_early", 32'(mem_req), 32'd0);
    applyStimulus(0, '0, '0, 0);
    checkOutput("sw_req", 32'(mem_req), 32'd1);
    checkOutput("sw_addr", 32'(mem_addr), 32'h10);
    checkOutput("sw_din", 32'(mem_din), 32'hA5);
    applyStimulus(0, '0, '0, 0);
    applyStimulus(0, '0, '0, 0);
    applyStimulus(0, '0, '0, 1);
    checkOutput("sw_req_done", 32'(mem_req), 32'd0);
    checkOutput("sw_busy_done", 32'(busy), 32'd0);

    // Overflow: 18 writes without ack, then clear via downloading rising edge.
    doReset();
    for (int i = 0; i < 18; i++) applyStimulus(1, 22'(32'h100 + i), 8'(i), 0);
    checkOutput("ov_level", 32'(level), 32'd16);
    checkOutput("ov_flag", 32'(overflow), 32'd1);
    checkOutput("ov_model_q", 32'(mq.size()), 32'd16);
    checkOutput("ov_inflight", 32'(mem_addr), 32'h100);
    downloading = 1'b1;
    applyStimulus(0, '0, '0, 0);
    checkOutput("ov_cleared", 32'(overflow), 32'd0);
    checkOutput("ov_level_kept", 32'(level), 32'd16);
    downloading = 1'b0;

    // Full FIFO, push coincident with ack: accepted, issued last.
    applyStimulus(1, 22'h3FFFFF, 8'hEE, 1);
    checkOutput("fp_level", 32'(level), 32'd16);
    checkOutput("fp_ovf", 32'(overflow), 32'd0);
    checkOutput("fp_addr", 32'(mem_addr), 32'h101);
    for (int i = 0; i < 16; i++) applyStimulus(0, '0, '0, 1);
    checkOutput("fp_last_addr", 32'(mem_addr), 32'h3FFFFF);
    checkOutput("fp_last_din", 32'(mem_din), 32'hEE);
    checkOutput("fp_level0", 32'(level), 32'd0);
    applyStimulus(0, '0, '0, 1);
    checkOutput("fp_idle", 32'(busy), 32'd0);

    // Timeout: request abandoned after TIMEOUT cycles; queued entry follows.
    doReset();
    applyStimulus(1, 22'h0000AA, 8'h11, 0);
    applyStimulus(1, 22'h0000BB, 8'h22, 0);
    n = 0;
    while (mem_req && n < 400) begin
      applyStimulus(0, '0, '0, 0);
      n++;
    end
    checkOutput("to_cycles", 32'(n), 32'd255);
    checkOutput("to_err", 32'(timeout_err), 32'd1);
    applyStimulus(0, '0, '0, 0);
    checkOutput("to_next_req", 32'(mem_req), 32'd1);
    checkOutput("to_next_addr", 32'(mem_addr), 32'hBB);

    // Reset mid-transaction with 5 queued.
    doReset();
    for (int i = 0; i < 6; i++) applyStimulus(1, 22'(32'h200 + i), 8'(i), 0);
    checkOutput("rm_level5", 32'(level), 32'd5);
    reset_n = 1'b0;
    applyStimulus(0, '0, '0, 0);
    checkOutput("rm_req", 32'(mem_req), 32'd0);
    checkOutput("rm_level", 32'(level), 32'd0);
    checkOutput("rm_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    applyStimulus(1, 22'h000010, 8'hA5, 0);
    applyStimulus(0, '0, '0, 0);
    checkOutput("rm_post_addr", 32'(mem_addr), 32'h10);
    checkOutput("rm_post_req", 32'(mem_req), 32'd1);

    // Random traffic, a slow-ack stretch to provoke timeouts, then traffic with rare resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) downloading = ~downloading;
      applyStimulus(bit'($urandom_range(0, 1)), 22'($urandom), 8'($urandom),
                    $urandom_range(0, 9) < 3);
    end
    for (int i = 0; i < 1200; i++)
      applyStimulus($urandom_range(0, 19) == 0, 22'($urandom), 8'($urandom), 0);
    for (int i = 0; i < 1000; i++) begin
      reset_n = ($urandom_range(0, 499) != 0);
      if ($urandom_range(0, 29) == 0) downloading = ~downloading;
      applyStimulus(bit'($urandom_range(0, 1)), 22'($urandom), 8'($urandom),
                    $urandom_range(0, 9) < 4);
    end
    reset_n = 1'b1;
    applyStimulus(0, '0, '0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
